// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Product width is always this multiple of the operand width.
   localparam int PWIDTH_FACTOR = 2;

   // Exact unsigned reference product for operands up to 32 bits.
   function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
      return {32'b0, a} * {32'b0, b};
   endfunction

endpackage

// File: rtl/ripple_adder.sv
// N-bit ripple-carry adder built from full-adder cells.
// The carry out of the top bit is not produced: the accumulator never overflows.
module ripple_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         cin,
   output logic [N-1:0] sum
);

   logic [N-1:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign sum[i] = x[i] ^ y[i] ^ carry[i];
      if (i < N - 1) begin : g_carry
         assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
      end
   end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Unsigned radix-2 shift-add multiplier, fixed latency of WIDTH cycles,
// valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one shift-add step per clock, busy high, WIDTH steps total
// DONE  | product presented with out_valid, held until out_ready
module seq_shift_add_mult
   import mult_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int PWIDTH = PWIDTH_FACTOR * WIDTH;
   localparam int CW     = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);

   state_t              state;
   logic [PWIDTH-1:0]   mcand;
   logic [WIDTH-1:0]    mplier;
   logic [PWIDTH-1:0]   acc;
   logic [CW-1:0]       count;
   logic [PWIDTH-1:0]   sum;
   logic [PWIDTH-1:0]   acc_next;

   ripple_adder #(.N(PWIDTH)) u_adder (
      .x   (acc),
      .y   (mcand),
      .cin (1'b0),
      .sum (sum)
   );

   // Accumulate only when the current multiplier bit is set.
   always_comb begin
      acc_next = mplier[0] ? sum : acc;
   end

   // Control FSM with shift registers, step counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         product   <= '0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         count     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand    <= {{WIDTH{1'b0}}, a};
                  mplier   <= b;
                  acc      <= '0;
                  count    <= '0;
                  state    <= CALC;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            CALC: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) begin
                  // Last step: capture the finished sum straight into the output.
                  product   <= acc_next;
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult at WIDTH = 4, 8, 2 and 16.
module tb_seq_shift_add_mult;
   import mult_pkg::*;

   localparam int NDUT = 4;
   localparam int WID [NDUT] = '{4, 8, 2, 16};

   typedef struct {
      logic [63:0] exp;
      int          t;
      int          id;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] a_s [NDUT];
   logic [31:0] b_s [NDUT];
   logic        in_valid [NDUT];
   logic        out_ready [NDUT];
   logic        in_ready [NDUT];
   logic        out_valid [NDUT];
   logic        busy [NDUT];
   logic [63:0] p_s [NDUT];
   logic [7:0]  p0;
   logic [15:0] p1;
   logic [3:0]  p2;
   logic [31:0] p3;

   txn_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic rnd_or = 1'b0;

   assign p_s[0] = 64'(p0);
   assign p_s[1] = 64'(p1);
   assign p_s[2] = 64'(p2);
   assign p_s[3] = 64'(p3);

   seq_shift_add_mult #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a_s[0][3:0]), .b(b_s[0][3:0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .product(p0), .busy(busy[0]));

   seq_shift_add_mult #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a_s[1][7:0]), .b(b_s[1][7:0]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .product(p1), .busy(busy[1]));

   seq_shift_add_mult #(.WIDTH(2)) u_w2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a(a_s[2][1:0]), .b(b_s[2][1:0]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .product(p2), .busy(busy[2]));

   seq_shift_add_mult #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
      .a(a_s[3][15:0]), .b(b_s[3][15:0]), .out_valid(out_valid[3]),
      .out_ready(out_ready[3]), .product(p3), .busy(busy[3]));

   always #5 clk = ~clk;

   // Edge counter: at a falling edge, cyc equals the number of rising edges so far.
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: timeout/unexpected (t=%0t)", name, $time);
   endtask

   // Present operands (called at a falling edge); returns at the falling edge after acceptance.
   task automatic send(input int id, input logic [31:0] av, input logic [31:0] bv);
      int n = 0;
      txn_t tx;
      a_s[id] = av;
      b_s[id] = bv;
      in_valid[id] = 1'b1;
      while (!in_ready[id] && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[id]) begin
         fail_now($sformatf("send_dut%0d", id));
         return;
      end
      tx.exp = ref_mult(av, bv);
      tx.t   = cyc + 1;
      tx.id  = id;
      sb_q.push_back(tx);
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while ((sb_q.size() != 0 || in_valid[0] || in_valid[1] || in_valid[2] || in_valid[3])
             && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) fail_now("drain");
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_valid(input int id);
      int n = 0;
      while (!out_valid[id] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid[id]) fail_now("wait_valid");
   endtask

   // Random consumer backpressure for the randomized phase.
   always @(negedge clk) begin
      if (rnd_or) begin
         for (int k = 0; k < NDUT; k++) out_ready[k] = 1'($urandom_range(0, 1));
      end
   end

   // One monitor per instance: latency, product, hold and handshake checks.
   for (genvar i = 0; i < NDUT; i++) begin : g_mon
      localparam int W = WID[i];
      logic prev_valid = 1'b0;
      logic chk_idle = 1'b0;
      always begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            prev_valid = 1'b0;
            chk_idle   = 1'b0;
         end else begin
            if (busy[i]) check($sformatf("ready_while_busy%0d", i), 64'(in_ready[i]), 64'd0);
            if (chk_idle) begin
               check($sformatf("idle_ready%0d", i), 64'(in_ready[i]), 64'd1);
               check($sformatf("idle_valid%0d", i), 64'(out_valid[i]), 64'd0);
               chk_idle = 1'b0;
            end
            if (out_valid[i]) begin
               if (sb_q.size() == 0 || sb_q[0].id != i) begin
                  fail_now($sformatf("spurious_valid%0d", i));
               end else begin
                  if (!prev_valid)
                     check($sformatf("latency%0d", i), 64'(cyc), 64'(sb_q[0].t + W));
                  check($sformatf("product%0d", i), p_s[i], sb_q[0].exp);
                  check($sformatf("done_ready%0d", i), 64'(in_ready[i]), 64'd0);
                  if (out_ready[i]) begin
                     void'(sb_q.pop_front());
                     chk_idle = 1'b1;
                  end
               end
            end
            prev_valid = out_valid[i];
         end
      end
   end

   initial begin
      logic [31:0] mask;
      for (int k = 0; k < NDUT; k++) begin
         a_s[k] = '0;
         b_s[k] = '0;
         in_valid[k] = 1'b0;
         out_ready[k] = 1'b1;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("rst_in_ready%0d", k), 64'(in_ready[k]), 64'd1);
         check($sformatf("rst_out_valid%0d", k), 64'(out_valid[k]), 64'd0);
         check($sformatf("rst_busy%0d", k), 64'(busy[k]), 64'd0);
         check($sformatf("rst_product%0d", k), p_s[k], 64'd0);
      end

      // Single operation 13 * 11.
      send(0, 32'd13, 32'd11);
      in_valid[0] = 1'b0;
      drain();

      // Exhaustive WIDTH=4, operands offered back to back.
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            send(0, 32'(x), 32'(y));
      in_valid[0] = 1'b0;
      drain();

      // Backpressure: 15*15 held while new operands wait at the input.
      out_ready[0] = 1'b0;
      send(0, 32'd15, 32'd15);
      fork
         begin
            send(0, 32'd5, 32'd6);
            in_valid[0] = 1'b0;
         end
      join_none
      wait_valid(0);
      repeat (5) @(negedge clk);
      check("bp_held_product", p_s[0], 64'd225);
      check("bp_held_valid", 64'(out_valid[0]), 64'd1);
      out_ready[0] = 1'b1;
      drain();

      // Reset mid-operation at WIDTH=8.
      send(1, 32'd200, 32'd3);
      in_valid[1] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 64'(in_ready[1]), 64'd1);
      check("midrst_out_valid", 64'(out_valid[1]), 64'd0);
      check("midrst_busy", 64'(busy[1]), 64'd0);
      check("midrst_product", p_s[1], 64'd0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(1, 32'd255, 32'd255);
      in_valid[1] = 1'b0;
      drain();

      // Narrow and wide instances.
      send(2, 32'd3, 32'd2);
      in_valid[2] = 1'b0;
      drain();
      send(3, 32'hFFFF, 32'd1);
      in_valid[3] = 1'b0;
      drain();

      // Randomized operands with random consumer backpressure.
      rnd_or = 1'b1;
      for (int k = 0; k < NDUT; k++) begin
         mask = (32'd1 << WID[k]) - 32'd1;
         send(k, mask, mask);
         repeat (15) send(k, $urandom & mask, $urandom & mask);
         in_valid[k] = 1'b0;
         drain();
      end
      rnd_or = 1'b0;
      for (int k = 0; k < NDUT; k++) out_ready[k] = 1'b1;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
